// File: rtl/pixel_arb_pkg.sv
// Shared types and constants for the pixel arbiter: FSM encoding,
// requester slot indices and colour width.
package pixel_arb_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        ISSUE      = 2'd1,
        WAIT_START = 2'd2,
        WAIT_DONE  = 2'd3
    } state_t;

    localparam int REQ_RESTORE  = 0;
    localparam int REQ_FILL     = 1;
    localparam int REQ_FREEHAND = 2;

    localparam int COLOR_W = 3;

endpackage

// File: rtl/pixel_arbiter_arb_select.sv
// Combinational winner selection: eligible mask -> one-hot winner and index.
// Fixed lowest-index priority, or round-robin from ptr_i when PIXEL_ARB_RR_EN is defined.
module arb_select #(
    parameter int N_REQ = 3,
    parameter int IW    = 2
) (
    input  logic [N_REQ-1:0] elig_i,
`ifdef PIXEL_ARB_RR_EN
    input  logic [IW-1:0]    ptr_i,
`endif
    output logic [N_REQ-1:0] win_oh_o,
    output logic [IW-1:0]    win_idx_o
);

`ifdef PIXEL_ARB_RR_EN
    int   j;
    logic found;

    // Walk the ring starting at the pointer; first eligible slot wins.
    always_comb begin
        win_oh_o  = '0;
        win_idx_o = '0;
        found     = 1'b0;
        j         = 0;
        for (int k = 0; k < N_REQ; k++) begin
            j = (int'(ptr_i) + k) % N_REQ;
            if (!found && elig_i[j]) begin
                found       = 1'b1;
                win_oh_o[j] = 1'b1;
                win_idx_o   = IW'(j);
            end
        end
    end
`else
    // Scan high to low so the lowest eligible index is the last write.
    always_comb begin
        win_oh_o  = '0;
        win_idx_o = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (elig_i[i]) begin
                win_oh_o    = '0;
                win_oh_o[i] = 1'b1;
                win_idx_o   = IW'(i);
            end
        end
    end
`endif

endmodule

// File: rtl/pixel_arbiter.sv
// Shares the packet generator between restore, fill and freehand pixel sources.
// Optional round-robin selection under PIXEL_ARB_RR_EN; default is fixed priority.
module pixel_arbiter
    import pixel_arb_pkg::*;
#(
    parameter int N_REQ      = 3,
    parameter int CW         = 8,
    parameter int START_WAIT = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_REQ-1:0]         req_valid,
    input  logic [N_REQ-1:0]         req_lock,
    input  logic [N_REQ*CW-1:0]      req_x,
    input  logic [N_REQ*CW-1:0]      req_y,
    input  logic [N_REQ*COLOR_W-1:0] req_color,
    output logic [N_REQ-1:0]         req_ready,
    output logic                     dn_trigger,
    output logic [CW-1:0]            dn_x,
    output logic [CW-1:0]            dn_y,
    output logic [COLOR_W-1:0]       dn_color,
    input  logic                     dn_busy,
    output logic [1:0]               grant_id,
    output logic                     arb_busy,
    output logic [15:0]              pix_count
);

    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    state_t             state_q, state_d;
    logic [N_REQ-1:0]   ready_q, ready_d;
    logic               trig_q, trig_d;
    logic [CW-1:0]      x_q, x_d, y_q, y_d;
    logic [COLOR_W-1:0] col_q, col_d;
    logic [1:0]         grant_q, grant_d;
    logic [15:0]        cnt_q, cnt_d;
    logic               park_q, park_d;
    logic [3:0]         wait_q, wait_d;
`ifdef PIXEL_ARB_RR_EN
    logic [IW-1:0]      ptr_q, ptr_d;
`endif

    logic [N_REQ-1:0]   gnt_oh, elig, win_oh;
    logic [IW-1:0]      win_idx;
    logic               lock_cur, park_eff;

    assign gnt_oh   = N_REQ'(1) << grant_q;
    assign lock_cur = |(req_lock & gnt_oh);
    // A parked grant releases the moment its owner drops the lock.
    assign park_eff = park_q & lock_cur;
    assign elig     = park_eff ? (req_valid & gnt_oh) : req_valid;

    arb_select #(.N_REQ(N_REQ), .IW(IW)) u_sel (
        .elig_i    (elig),
`ifdef PIXEL_ARB_RR_EN
        .ptr_i     (ptr_q),
`endif
        .win_oh_o  (win_oh),
        .win_idx_o (win_idx)
    );

    always_comb begin
        state_d = state_q;
        ready_d = '0;
        trig_d  = 1'b0;
        x_d     = x_q;
        y_d     = y_q;
        col_d   = col_q;
        grant_d = grant_q;
        cnt_d   = cnt_q;
        park_d  = park_q;
        wait_d  = wait_q;
`ifdef PIXEL_ARB_RR_EN
        ptr_d   = ptr_q;
`endif
        case (state_q)
            IDLE: begin
                park_d = park_eff;
                if (|elig) begin
                    for (int i = 0; i < N_REQ; i++) begin
                        if (win_oh[i]) begin
                            x_d   = req_x[i*CW +: CW];
                            y_d   = req_y[i*CW +: CW];
                            col_d = req_color[i*COLOR_W +: COLOR_W];
                        end
                    end
                    grant_d = 2'(win_idx);
                    ready_d = win_oh;
                    cnt_d   = cnt_q + 16'd1;
                    state_d = ISSUE;
`ifdef PIXEL_ARB_RR_EN
                    if (!park_eff)
                        ptr_d = (win_idx == IW'(N_REQ - 1)) ? '0 : win_idx + 1'b1;
`endif
                end
            end
            ISSUE: begin
                trig_d  = 1'b1;
                wait_d  = '0;
                state_d = WAIT_START;
            end
            WAIT_START: begin
                // Busy already high here (even stale) counts as burst start.
                if (dn_busy) begin
                    state_d = WAIT_DONE;
                end else if (wait_q == 4'(START_WAIT)) begin
                    state_d = IDLE;
                    park_d  = lock_cur;
                end else begin
                    wait_d = wait_q + 4'd1;
                end
            end
            WAIT_DONE: begin
                if (!dn_busy) begin
                    state_d = IDLE;
                    park_d  = lock_cur;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ready_q <= '0;
            trig_q  <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
            col_q   <= '0;
            grant_q <= '0;
            cnt_q   <= '0;
            park_q  <= 1'b0;
            wait_q  <= '0;
`ifdef PIXEL_ARB_RR_EN
            ptr_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            ready_q <= ready_d;
            trig_q  <= trig_d;
            x_q     <= x_d;
            y_q     <= y_d;
            col_q   <= col_d;
            grant_q <= grant_d;
            cnt_q   <= cnt_d;
            park_q  <= park_d;
            wait_q  <= wait_d;
`ifdef PIXEL_ARB_RR_EN
            ptr_q   <= ptr_d;
`endif
        end
    end

    assign req_ready  = ready_q;
    assign dn_trigger = trig_q;
    assign dn_x       = x_q;
    assign dn_y       = y_q;
    assign dn_color   = col_q;
    assign grant_id   = grant_q;
    assign arb_busy   = (state_q != IDLE);
    assign pix_count  = cnt_q;

endmodule
